// File: rtl/xbar_pkg.sv
// Shared types for the crossbar master-side request buffer: default bus
// widths, command encoding, the buffered request entry and the downstream
// issue FSM states.
`timescale 1ns/1ps
package xbar_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  // Entry layout at the default widths.
  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    cmd_e                     cmd;
    logic [DATA_WIDTH-1:0]    wdata;
  } req_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } state_e;

endpackage

// File: rtl/xbar_sync_fifo.sv
// Single-clock FIFO for request entries. The entry type is a parameter so the
// caller decides the payload layout. Push while full and pop while empty are
// ignored; a pop in the same cycle never frees room for a push.
`timescale 1ns/1ps
module xbar_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_LEVEL = (AW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  // Storage write.
  // NOTE: the storage array has no reset; only pointers and level need a
  // defined value, and stale entries are never read while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/xbar_master_req_buffer.sv
// Per-master request buffer in front of one crossbar master port. Writes are
// posted into a FIFO and acked at once; reads block the master until the
// crossbar returns data. Entries are replayed strictly in order.
// Optional watchdog: define XBAR_REQ_BUF_TIMEOUT_EN to abandon a downstream
// request after TIMEOUT_CYCLES without dn_ack and raise the sticky err port.
`timescale 1ns/1ps
module xbar_master_req_buffer #(
  parameter int ADDR_WIDTH     = xbar_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH     = xbar_pkg::DATA_WIDTH,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   up_req,
  input  logic [ADDR_WIDTH-1:0]  up_addr,
  input  logic                   up_cmd,
  input  logic [DATA_WIDTH-1:0]  up_wdata,
  output logic                   up_ack,
  output logic [DATA_WIDTH-1:0]  up_rdata,
  output logic                   dn_req,
  output logic [ADDR_WIDTH-1:0]  dn_addr,
  output logic                   dn_cmd,
  output logic [DATA_WIDTH-1:0]  dn_wdata,
  input  logic                   dn_ack,
  input  logic [DATA_WIDTH-1:0]  dn_rdata,
`ifdef XBAR_REQ_BUF_TIMEOUT_EN
  output logic                   err,
`endif
  output logic [$clog2(DEPTH):0] level
);

  import xbar_pkg::*;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    cmd_e                  cmd;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  state_e state;
  state_e state_next;
  entry_t push_entry;
  entry_t head;
  logic   full;
  logic   empty;
  logic   accept;
  logic   pop;
  logic   done;
  logic   read_done;
  logic   read_pending;
  logic   timed_out;

  // Upstream acceptance: up_ack blocks a second accept of the same request.
  assign accept     = up_req && !up_ack && !read_pending && !full;
  assign push_entry = '{addr: up_addr, cmd: cmd_e'(up_cmd), wdata: up_wdata};
  assign read_done  = done && (cmd_e'(dn_cmd) == CMD_READ);

  xbar_sync_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Downstream issue FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and pop decision; a completing entry is replaced back-to-back.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (dn_ack || timed_out) begin
          done = 1'b1;
          if (!empty) pop = 1'b1;
          else        state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Downstream payload registers: loaded on pop, held stable until completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dn_req   <= 1'b0;
      dn_addr  <= '0;
      dn_cmd   <= 1'b0;
      dn_wdata <= '0;
    end else if (pop) begin
      dn_req   <= 1'b1;
      dn_addr  <= head.addr;
      dn_cmd   <= head.cmd;
      dn_wdata <= head.wdata;
    end else if (done) begin
      dn_req   <= 1'b0;
    end
  end

  // Upstream completion: posted writes ack right after accept, reads ack after
  // their downstream completion. The two cannot coincide (read_pending).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_ack       <= 1'b0;
      up_rdata     <= '0;
      read_pending <= 1'b0;
    end else begin
      up_ack <= (accept && cmd_e'(up_cmd) == CMD_WRITE) || read_done;
      if (read_done) up_rdata <= timed_out ? '1 : dn_rdata;
      if (accept && cmd_e'(up_cmd) == CMD_READ) read_pending <= 1'b1;
      else if (read_done)                       read_pending <= 1'b0;
    end
  end

`ifdef XBAR_REQ_BUF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;

  assign timed_out = (state == ST_ISSUE) && !dn_ack &&
                     (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts ISSUE cycles of the current entry; sticky err on expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != ST_ISSUE || done) wd_cnt <= '0;
      else                           wd_cnt <= wd_cnt + 1'b1;
      if (timed_out) err <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timed_out      = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_xbar_master_req_buffer.sv
// Self-checking bench for xbar_master_req_buffer. A scoreboard queue holds the
// downstream transactions expected in order; a second queue holds expected
// read data. A downstream responder model acks with a selectable policy.
// Build with XBAR_REQ_BUF_TIMEOUT_EN defined to exercise the watchdog.
`timescale 1ns/1ps
module tb_xbar_master_req_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          cmd;
    logic [DW-1:0] wdata;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   up_req;
  logic [AW-1:0]          up_addr;
  logic                   up_cmd;
  logic [DW-1:0]          up_wdata;
  logic                   up_ack;
  logic [DW-1:0]          up_rdata;
  logic                   dn_req;
  logic [AW-1:0]          dn_addr;
  logic                   dn_cmd;
  logic [DW-1:0]          dn_wdata;
  logic                   dn_ack;
  logic [DW-1:0]          dn_rdata;
  logic [$clog2(DEPTH):0] level;
`ifdef XBAR_REQ_BUF_TIMEOUT_EN
  logic                   err;
`endif

  int      n_checks = 0;
  int      n_errors = 0;
  exp_t    dn_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] sh_mem [16];
  logic [DW-1:0] mem_dn [16];
  int      ack_mode = 0;   // 0: idle / single pulses, 1: tied high, 2: delayed
  int      ack_delay = 0;
  int      pulses_req = 0;
  int      pulses_done = 0;
  time     last_hs_time = 0;

  xbar_master_req_buffer #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .up_req   (up_req),
    .up_addr  (up_addr),
    .up_cmd   (up_cmd),
    .up_wdata (up_wdata),
    .up_ack   (up_ack),
    .up_rdata (up_rdata),
    .dn_req   (dn_req),
    .dn_addr  (dn_addr),
    .dn_cmd   (dn_cmd),
    .dn_wdata (dn_wdata),
    .dn_ack   (dn_ack),
    .dn_rdata (dn_rdata),
`ifdef XBAR_REQ_BUF_TIMEOUT_EN
    .err      (err),
`endif
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Record the expected downstream transaction and drive the master request.
  task automatic drive_req(input logic [AW-1:0] a, input logic c, input logic [DW-1:0] d);
    exp_t e;
    e.addr  = a;
    e.cmd   = c;
    e.wdata = d;
    dn_q.push_back(e);
    if (c) sh_mem[a[3:0]] = d;
    else   rd_q.push_back(sh_mem[a[3:0]]);
    up_addr  = a;
    up_cmd   = c;
    up_wdata = d;
    up_req   = 1'b1;
  endtask

  // Full master transaction; lat counts clock cycles from drive to up_ack.
  task automatic master_req(input logic [AW-1:0] a, input logic c, input logic [DW-1:0] d,
                            input int budget, output int lat);
    logic [DW-1:0] exp_rd;
    int n = 0;
    drive_req(a, c, d);
    forever begin
      @(negedge clk);
      if (up_ack || n >= budget) break;
      n++;
    end
    lat = n;
    check("up_ack_seen", up_ack, 1'b1);
    if (up_ack && !c) begin
      exp_rd = rd_q.pop_front();
      check("up_rdata", up_rdata, exp_rd);
      check("rd_order", dn_q.size(), 0);
      check("rd_ack_after_dn_ack", $time - last_hs_time, 10);
    end
    @(posedge clk); #1;
    up_req = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((dn_q.size() != 0 || dn_req) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_q", dn_q.size(), 0);
    check("drain_req", dn_req, 1'b0);
    @(posedge clk); #1;
  endtask

  // Downstream responder; acts after the main driver within each cycle.
  initial begin
    int wait_cnt = 0;
    dn_ack   = 1'b0;
    dn_rdata = '0;
    forever begin
      @(posedge clk); #2;
      case (ack_mode)
        1: dn_ack = 1'b1;
        2: begin
          if (dn_ack) begin
            dn_ack   = 1'b0;
            wait_cnt = 0;
          end else if (dn_req) begin
            if (wait_cnt >= ack_delay) dn_ack = 1'b1;
            else                       wait_cnt++;
          end else begin
            wait_cnt = 0;
          end
        end
        default: begin
          if (!dn_ack && pulses_done < pulses_req) begin
            dn_ack = 1'b1;
            pulses_done++;
          end else begin
            dn_ack = 1'b0;
          end
        end
      endcase
      dn_rdata = mem_dn[dn_addr[3:0]];
    end
  end

  // Downstream monitor: every handshake is compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && dn_req && dn_ack) begin
        if (dn_q.size() == 0) begin
          check("dn_unexpected_hs", dn_ack, 1'b0);
        end else begin
          e = dn_q.pop_front();
          check("dn_addr", dn_addr, e.addr);
          check("dn_cmd", dn_cmd, e.cmd);
          if (e.cmd) begin
            check("dn_wdata", dn_wdata, e.wdata);
            mem_dn[dn_addr[3:0]] = dn_wdata;
          end
        end
        last_hs_time = $time;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int lat;
    int n;
    int gap;
    int hi;
    logic [DW-1:0] exp_rd;

    for (int i = 0; i < 16; i++) begin
      sh_mem[i] = '0;
      mem_dn[i] = '0;
    end
    reset    = 1'b0;
    up_req   = 1'b0;
    up_addr  = '0;
    up_cmd   = 1'b0;
    up_wdata = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_up_ack", up_ack, 1'b0);
    check("rst_up_rdata", up_rdata, 0);
    check("rst_dn_req", dn_req, 1'b0);
    check("rst_dn_addr", dn_addr, 0);
    check("rst_dn_cmd", dn_cmd, 1'b0);
    check("rst_dn_wdata", dn_wdata, 0);
    check("rst_level", level, 0);
`ifdef XBAR_REQ_BUF_TIMEOUT_EN
    check("rst_err", err, 1'b0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    // Four back-to-back posted writes, crossbar always ready.
    ack_mode = 1;
    for (int i = 0; i < 4; i++) begin
      master_req(i, 1'b1, 32'hA0 + i, 10, lat);
      check("t2_ack_latency", lat, 1);
    end
    wait_drain(20);

    // Fill: one entry sits in the dn registers, four more fill the FIFO.
    ack_mode = 0;
    for (int i = 0; i < 5; i++) begin
      master_req(4 + i, 1'b1, 32'hB0 + i, 10, lat);
      check("t3_ack_latency", lat, 1);
    end
    @(negedge clk);
    check("t3_level_full", level, 4);
    @(posedge clk); #1;
    drive_req(9, 1'b1, 32'hB5);
    repeat (3) begin
      @(negedge clk);
      check("t3_stall_no_ack", up_ack, 1'b0);
      check("t3_stall_level", level, 4);
    end
    @(posedge clk); #1;
    pulses_req++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (level != 3 && n < 10);
    check("t3_level_drop", level, 3);
    @(negedge clk);
    check("t3_late_ack", up_ack, 1'b1);
    check("t3_level_refill", level, 4);
    @(posedge clk); #1;
    up_req   = 1'b0;
    ack_mode = 1;
    wait_drain(30);

    // Write then read of the same address with a slow crossbar.
    ack_mode  = 2;
    ack_delay = 5;
    master_req(2, 1'b1, 32'h11, 10, lat);
    check("t4_write_posted", lat, 1);
    master_req(2, 1'b0, 32'h0, 60, lat);
    wait_drain(20);

    // Write presented while a read is still pending.
    ack_delay = 3;
    drive_req(3, 1'b0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    drive_req(12, 1'b1, 32'h55);
    n = 0;
    forever begin
      @(negedge clk);
      if (up_ack || n >= 40) break;
      n++;
    end
    check("t5_read_ack", up_ack, 1'b1);
    exp_rd = rd_q.pop_front();
    check("t5_read_rdata", up_rdata, exp_rd);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!up_ack && gap < 10);
    check("t5_write_ack_gap", gap, 2);
    @(posedge clk); #1;
    up_req = 1'b0;
    wait_drain(40);

    // Asynchronous reset while a request is issued downstream.
    ack_mode = 0;
    master_req(15, 1'b1, 32'hE0, 10, lat);
    master_req(14, 1'b1, 32'hE1, 10, lat);
    n = 0;
    while (!dn_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t1_issue_before_rst", dn_req, 1'b1);
    check("t1_level_before_rst", level, 1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("t1_async_dn_req", dn_req, 1'b0);
    check("t1_async_up_ack", up_ack, 1'b0);
    check("t1_async_level", level, 0);
    check("t1_async_dn_addr", dn_addr, 0);
    dn_q.delete();
    rd_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t1_idle_dn_req", dn_req, 1'b0);
      check("t1_idle_level", level, 0);
    end
    @(posedge clk); #1;
    ack_mode = 1;
    master_req(1, 1'b1, 32'hC1, 10, lat);
    check("t1_post_rst_latency", lat, 1);
    wait_drain(20);
    master_req(1, 1'b0, 32'h0, 20, lat);
    wait_drain(20);

`ifdef XBAR_REQ_BUF_TIMEOUT_EN
    // Read never acked downstream: abandoned by the watchdog.
    check("t6_err_clear", err, 1'b0);
    ack_mode = 0;
    up_addr  = 2;
    up_cmd   = 1'b0;
    up_wdata = '0;
    up_req   = 1'b1;
    hi = 0;
    n  = 0;
    forever begin
      @(negedge clk);
      if (up_ack || n >= 60) break;
      if (dn_req) hi++;
      n++;
    end
    check("t6_ack", up_ack, 1'b1);
    check("t6_rdata_ones", up_rdata, 32'hFFFF_FFFF);
    check("t6_req_cycles", hi, TO);
    check("t6_dn_req_drop", dn_req, 1'b0);
    check("t6_err_set", err, 1'b1);
    @(posedge clk); #1;
    up_req = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_err_sticky", err, 1'b1);
    @(posedge clk); #1;
    ack_mode = 1;
    master_req(5, 1'b1, 32'hD5, 10, lat);
    wait_drain(20);
    check("t6_err_still", err, 1'b1);
`endif

    check("end_dn_q_empty", dn_q.size(), 0);
    check("end_rd_q_empty", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
